// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts load/store requests, waits a programmable
// number of cycles, then returns registered read data and an error flag.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              addr_misaligned;
    logic              addr_out_of_range;

    assign addr_misaligned   = |req_addr[1:0];
    assign addr_out_of_range = 32'(req_addr[ADDR_W-1:2]) >= 32'(DEPTH);

    // WAIT counts down from LATENCY to 0 and commits on the edge that sees 0,
    // so resp_valid rises LATENCY+1 edges after the accept (also for LATENCY=0).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d    = req_write;
                    idx_d   = req_addr[ADDR_W-1:2];
                    wdata_d = req_wdata;
                    err_d   = addr_misaligned || addr_out_of_range;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    mem_we       = wr_q && !err_q;
                    resp_rdata_d = (!wr_q && !err_q) ? mem_q[MEM_AW'(idx_q)] : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[MEM_AW'(i)] <= '0;
            end
        end else if (mem_we) begin
            mem_q[MEM_AW'(idx_q)] <= wdata_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with LATENCY=2 and
// one with LATENCY=0, driven by directed requests with hand-computed results.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [7:0]  req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .LATENCY(2)) dut_l2 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .LATENCY(0)) dut_l0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   prev_v [2];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got no-event/unexpected expected handshake", name);
    endtask

    function automatic int first_of(input int d);
        foreach (sbq[i]) if (sbq[i].dut == d) return i;
        return -1;
    endfunction

    // Monitor: checks the rising edge timing and the consumed response contents.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            int k;
            k = first_of(d);
            if (resp_valid[d] === 1'b1 && !prev_v[d]) begin
                if (k < 0) fail_now($sformatf("unexpected_resp_dut%0d", d));
                else chk($sformatf("resp_edge_dut%0d", d), 32'(cyc), 32'(sbq[k].cyc));
            end
            if (resp_valid[d] === 1'b1 && resp_ready[d] && k >= 0) begin
                chk($sformatf("rdata_dut%0d", d), resp_rdata[d], sbq[k].rdata);
                chk($sformatf("err_dut%0d", d), 32'(resp_err[d]), 32'(sbq[k].err));
                sbq.delete(k);
            end
            prev_v[d] = (resp_valid[d] === 1'b1);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int d, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input bit expect_resp, output int acc);
        exp_t e;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        acc = -1;
        for (int n = 0; n < 100 && !req_ready[d]; n++) tick;
        if (!req_ready[d]) begin
            fail_now($sformatf("accept_timeout_dut%0d", d));
            req_valid[d] = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (expect_resp) begin
            e.dut   = d;
            e.rdata = er;
            e.err   = ee;
            e.cyc   = acc + 1 + ((d == 0) ? 2 : 0);
            sbq.push_back(e);
        end
        tick;
        req_valid[d] = 1'b0;
    endtask

    task automatic drain;
        for (int n = 0; n < 200 && sbq.size() != 0; n++) tick;
        if (sbq.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            resp_ready[d] = 1'b1;
            prev_v[d]     = 1'b0;
        end
        tick;
        tick;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready_dut%0d", d), 32'(req_ready[d]), 32'd0);
            chk($sformatf("rst_valid_dut%0d", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("rst_rdata_dut%0d", d), resp_rdata[d], 32'd0);
            chk($sformatf("rst_err_dut%0d", d), 32'(resp_err[d]), 32'd0);
        end
        reset = 1'b0;
        tick;
        for (int d = 0; d < 2; d++)
            chk($sformatf("post_rst_ready_dut%0d", d), 32'(req_ready[d]), 32'd1);

        // Store with resp_ready already high: ready drops after t, returns after t+4.
        issue(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, t);
        chk("t1_ready_low", 32'(req_ready[0]), 32'd0);
        repeat (4) tick;
        chk("t1_ready_back", 32'(req_ready[0]), 32'd1);

        issue(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, t);
        issue(0, 1'b0, 8'h14, 32'h0, 32'h00000000, 1'b0, 1'b1, t);

        issue(0, 1'b0, 8'h11, 32'h0, 32'h0, 1'b1, 1'b1, t);
        issue(0, 1'b1, 8'h22, 32'h1, 32'h0, 1'b1, 1'b1, t);
        issue(0, 1'b0, 8'h20, 32'h0, 32'h0, 1'b0, 1'b1, t);
        drain;

        // Backpressure: response must hold still while resp_ready is low.
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, t);
        for (int n = 0; n < 50 && !resp_valid[0]; n++) tick;
        if (!resp_valid[0]) fail_now("t4_resp_timeout");
        for (int n = 0; n < 5; n++) begin
            chk("t4_hold_valid", 32'(resp_valid[0]), 32'd1);
            chk("t4_hold_rdata", resp_rdata[0], 32'hDEADBEEF);
            chk("t4_hold_err", 32'(resp_err[0]), 32'd0);
            chk("t4_hold_ready", 32'(req_ready[0]), 32'd0);
            tick;
        end
        resp_ready[0] = 1'b1;
        tick;
        chk("t4_valid_drop", 32'(resp_valid[0]), 32'd0);
        chk("t4_idle_ready", 32'(req_ready[0]), 32'd1);

        // Zero-latency instance.
        issue(1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b1, t);
        issue(1, 1'b1, 8'hFC, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, t);
        issue(1, 1'b0, 8'hFC, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, t);
        drain;

        // Reset one cycle after accepting a store: no response, array cleared.
        issue(0, 1'b1, 8'h08, 32'h12345678, 32'h0, 1'b0, 1'b0, t);
        reset = 1'b1;
        tick;
        chk("t6_rst1_valid", 32'(resp_valid[0]), 32'd0);
        chk("t6_rst1_ready", 32'(req_ready[0]), 32'd0);
        tick;
        chk("t6_rst2_valid", 32'(resp_valid[0]), 32'd0);
        chk("t6_rst2_ready", 32'(req_ready[0]), 32'd0);
        reset = 1'b0;
        tick;
        chk("t6_ready_after", 32'(req_ready[0]), 32'd1);
        chk("t6_no_resp", 32'(resp_valid[0]), 32'd0);
        issue(0, 1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 1'b1, t);
        issue(1, 1'b0, 8'hFC, 32'h0, 32'h0, 1'b0, 1'b1, t);
        drain;
        repeat (3) tick;
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
